// File: rtl/inst_queue_if.sv
// IF->ID instruction queue handshake bundle: upstream offer/accept, downstream head/accept, redirect flush, occupancy.
// slave is the queue side; master is the IF/ID side driving offers, accepts and flush.
interface inst_queue_if #(
    parameter int DEPTH   = 4,
    parameter int BUS_LEN = 80
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               in_valid;
    logic [BUS_LEN-1:0] in_bus;
    logic               in_ready;
    logic               out_valid;
    logic [BUS_LEN-1:0] out_bus;
    logic               out_ready;
    logic               flush;
    logic [CNT_W-1:0]   count;

    modport master (
        output in_valid, in_bus, out_ready, flush,
        input  in_ready, out_valid, out_bus, count
    );

    modport slave (
        input  in_valid, in_bus, out_ready, flush,
        output in_ready, out_valid, out_bus, count
    );
endinterface

// File: rtl/inst_queue.sv
// IF->ID instruction FIFO, 1-cycle minimum latency with no bypass; in_ready drops when full, on a queued exception entry or on flush,
// and is independent of out_ready. A full queue refuses a push even while popping; exception entries block further pushes until flush.
module inst_queue #(
    parameter int DEPTH   = 4,
    parameter int BUS_LEN = 80
) (
    input  logic          clk,
    input  logic          resetn,
    inst_queue_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [BUS_LEN-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ex_block_q, ex_block_d;
    logic               push, pop, in_has_ex;

    assign bus.in_ready  = resetn & (count_q != FULL_CNT) & ~ex_block_q & ~bus.flush;
    assign bus.out_valid = (count_q != '0) & ~bus.flush;
    assign bus.out_bus   = mem_q[head_q];
    assign bus.count     = count_q;

    assign push      = bus.in_valid & bus.in_ready;
    assign pop       = bus.out_valid & bus.out_ready;
    assign in_has_ex = bus.in_bus[BUS_LEN-1 -: 16] != 16'h0;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        ex_block_d = ex_block_q;
        if (bus.flush) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            ex_block_d = 1'b0;
        end else begin
            if (pop)  head_d = head_q + PTR_W'(1);
            if (push) tail_d = tail_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
            if (push && in_has_ex) ex_block_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ex_block_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ex_block_q <= ex_block_d;
        end
    end

    // Payload storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= bus.in_bus;
    end
endmodule

// File: tb/tb_inst_queue.sv
// Directed and random stimulus against a queue-based reference model of the instruction queue.
module tb_inst_queue;
    localparam int DEPTH   = 4;
    localparam int BUS_LEN = 80;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [BUS_LEN-1:0] model[$];
    bit                 model_ex = 1'b0;

    inst_queue_if #(.DEPTH(DEPTH), .BUS_LEN(BUS_LEN)) q_if ();

    inst_queue #(.DEPTH(DEPTH), .BUS_LEN(BUS_LEN)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (q_if.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [BUS_LEN-1:0] mk(input logic [15:0] ebus, input logic [31:0] pc);
        mk = {ebus, ~pc, pc};
    endfunction

    task automatic chk(input string tag, input logic [BUS_LEN-1:0] obs, input logic [BUS_LEN-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check against the model, advance the model at posedge.
    task automatic cyc(input logic iv, input logic [BUS_LEN-1:0] ib, input logic ordy, input logic fl);
        logic exp_ov, exp_ir;
        @(negedge clk);
        q_if.in_valid  = iv;
        q_if.in_bus    = ib;
        q_if.out_ready = ordy;
        q_if.flush     = fl;
        #1;
        exp_ov = (model.size() != 0) && !fl;
        exp_ir = resetn && (model.size() != DEPTH) && !model_ex && !fl;
        chk("out_valid", BUS_LEN'(q_if.out_valid), BUS_LEN'(exp_ov));
        chk("in_ready",  BUS_LEN'(q_if.in_ready),  BUS_LEN'(exp_ir));
        chk("count",     BUS_LEN'(q_if.count),     BUS_LEN'(model.size()));
        if (exp_ov) chk("out_bus", q_if.out_bus, model[0]);
        @(posedge clk);
        if (fl) begin
            model.delete();
            model_ex = 1'b0;
        end else begin
            if (exp_ov && ordy) void'(model.pop_front());
            if (exp_ir && iv) begin
                model.push_back(ib);
                if (ib[BUS_LEN-1 -: 16] != 16'h0) model_ex = 1'b1;
            end
        end
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b0, '0, ordy, 1'b0);
    endtask

    initial begin
        logic [31:0] pc;
        q_if.in_valid  = 1'b0;
        q_if.in_bus    = '0;
        q_if.out_ready = 1'b0;
        q_if.flush     = 1'b0;

        // Held in reset: everything idle, nothing accepted.
        #12;
        chk("rst_count",     BUS_LEN'(q_if.count),     '0);
        chk("rst_out_valid", BUS_LEN'(q_if.out_valid), '0);
        chk("rst_in_ready",  BUS_LEN'(q_if.in_ready),  '0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("post_rst_in_ready",  BUS_LEN'(q_if.in_ready),  BUS_LEN'(1));
        chk("post_rst_out_valid", BUS_LEN'(q_if.out_valid), '0);

        // Fill four entries with ID stalled, then drain in order.
        pc = 32'h1c00_0000;
        for (int i = 0; i < 4; i++) cyc(1'b1, mk(16'h0, pc + 32'(4 * i)), 1'b0, 1'b0);
        cyc(1'b1, mk(16'h0, 32'hdead_0000), 1'b0, 1'b0);
        chk("full_count", BUS_LEN'(q_if.count), BUS_LEN'(4));
        for (int i = 0; i < 5; i++) idle(1'b1);
        chk("drained_count", BUS_LEN'(q_if.count), '0);

        // Single entry latency with ID always accepting.
        cyc(1'b1, mk(16'h0, 32'h1c00_0100), 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Simultaneous push/pop at count 2 across the tail wrap.
        cyc(1'b1, mk(16'h0, 32'h1c00_0200), 1'b0, 1'b0);
        cyc(1'b1, mk(16'h0, 32'h1c00_0204), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, mk(16'h0, 32'h1c00_0208 + 32'(4 * i)), 1'b1, 1'b0);
        chk("wrap_count", BUS_LEN'(q_if.count), BUS_LEN'(2));
        idle(1'b1);
        idle(1'b1);

        // Flush at count 3 while offering and accepting.
        for (int i = 0; i < 3; i++) cyc(1'b1, mk(16'h0, 32'h1c00_0300 + 32'(4 * i)), 1'b0, 1'b0);
        cyc(1'b1, mk(16'h0, 32'hbad0_0000), 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Flush on an empty queue.
        cyc(1'b0, '0, 1'b1, 1'b1);
        idle(1'b1);

        // Exception entry behind two normal entries blocks intake until flush.
        cyc(1'b1, mk(16'h0, 32'h1c00_0400), 1'b0, 1'b0);
        cyc(1'b1, mk(16'h0, 32'h1c00_0404), 1'b0, 1'b0);
        cyc(1'b1, mk(16'h0040, 32'h1c00_0408), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, mk(16'h0, 32'h1c00_0500 + 32'(4 * i)), 1'b1, 1'b0);
        chk("ex_blocked_in_ready", BUS_LEN'(q_if.in_ready), '0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        idle(1'b0);
        chk("ex_cleared_in_ready", BUS_LEN'(q_if.in_ready), BUS_LEN'(1));

        // Asynchronous reset mid-cycle with two entries queued.
        cyc(1'b1, mk(16'h0, 32'h1c00_0600), 1'b0, 1'b0);
        cyc(1'b1, mk(16'h0, 32'h1c00_0604), 1'b0, 1'b0);
        @(negedge clk);
        q_if.in_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_count",     BUS_LEN'(q_if.count),     '0);
        chk("arst_out_valid", BUS_LEN'(q_if.out_valid), '0);
        chk("arst_in_ready",  BUS_LEN'(q_if.in_ready),  '0);
        model.delete();
        model_ex = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("arst_rel_in_ready", BUS_LEN'(q_if.in_ready), BUS_LEN'(1));

        // Random traffic with occasional flushes and exception entries.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] eb;
            eb = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(1, 16'hffff)) : 16'h0;
            cyc(1'($urandom_range(0, 1)), mk(eb, $urandom), 1'($urandom_range(0, 2) != 0),
                ($urandom_range(0, 19) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
